// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives PC enable/next value, imem req/ready handshake,
// holds the fetched instruction for decode and applies execute redirects.
module fetch_ctrl #(
  parameter int N       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_pc,
  output logic         o_en_pc,
  output logic [N-1:0] o_pc_next,
  output logic         o_imem_req,
  output logic [N-1:0] o_imem_addr,
  input  logic         i_imem_ready,
  input  logic [31:0]  i_imem_rdata,
  output logic [31:0]  o_instr,
  output logic         o_instr_valid,
  input  logic         i_stall,
  input  logic         i_redirect,
  input  logic [N-1:0] i_redirect_pc,
  output logic         o_misalign,
  output logic         o_timeout
);

  typedef enum logic [1:0] {
    START,
    FETCH,
    FLUSH,
    ISSUE
  } state_t;

  localparam logic [7:0] TO = TIMEOUT[7:0];
  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic [N-1:0] saved;
  logic [N-1:0] tgt;
  logic [N-1:0] pc_inc;
  logic mis;
  logic waiting;

  assign tgt = {i_redirect_pc[N-1:2], 2'b00};
  assign pc_inc = i_pc + N'(4);
  assign o_imem_addr = i_pc;
  assign mis = i_redirect && (state != START)
             && (i_redirect_pc[1:0] != 2'b00);
  assign waiting = (state == FETCH || state == FLUSH)
                 && !i_imem_ready;

  always_comb begin
    o_en_pc = 1'b0;
    o_imem_req = 1'b0;
    o_pc_next = pc_inc;
    unique case (state)
      FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ready) begin
          o_en_pc = 1'b1;
          if (i_redirect) o_pc_next = tgt;
        end
      end
      FLUSH: begin
        o_imem_req = 1'b1;
        if (i_imem_ready) begin
          o_en_pc = 1'b1;
          o_pc_next = i_redirect ? tgt : saved;
        end
      end
      ISSUE: begin
        if (i_redirect) begin
          o_en_pc = 1'b1;
          o_pc_next = tgt;
        end
      end
      default: ;
    endcase
  end

  // Saturating count of cycles an outstanding request has waited
  always_comb begin
    wait_nxt = 8'd0;
    if (waiting)
      wait_nxt = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= START;
      o_instr <= NOP;
      o_instr_valid <= 1'b0;
      o_misalign <= 1'b0;
      o_timeout <= 1'b0;
      wait_cnt <= 8'd0;
      saved <= '0;
    end else begin
      o_misalign <= mis;
      wait_cnt <= wait_nxt;
      if (waiting && wait_nxt == TO) o_timeout <= 1'b1;
      unique case (state)
        START: state <= FETCH;
        FETCH: begin
          if (i_imem_ready && !i_redirect) begin
            o_instr <= i_imem_rdata;
            o_instr_valid <= 1'b1;
            state <= ISSUE;
          end else if (!i_imem_ready && i_redirect) begin
            saved <= tgt;
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (i_redirect) saved <= tgt;
          if (i_imem_ready) state <= FETCH;
        end
        ISSUE: begin
          if (i_redirect || !i_stall) begin
            o_instr_valid <= 1'b0;
            state <= FETCH;
          end
        end
        default: state <= START;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural PC register.
module tb_fetch_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_rst = 32'h0;
  logic        en_pc;
  logic [31:0] pc_next;
  logic        req;
  logic [31:0] addr;
  logic        ready = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [31:0] instr;
  logic        valid;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic        misalign;
  logic        timeout;

  int n_vec = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk or negedge i_rst)
    if (!i_rst) pc <= pc_rst;
    else if (en_pc) pc <= pc_next;

  fetch_ctrl #(.N(32), .TIMEOUT(4)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_pc(pc),
    .o_en_pc(en_pc),
    .o_pc_next(pc_next),
    .o_imem_req(req),
    .o_imem_addr(addr),
    .i_imem_ready(ready),
    .i_imem_rdata(rdata),
    .o_instr(instr),
    .o_instr_valid(valid),
    .i_stall(stall),
    .i_redirect(redir),
    .i_redirect_pc(redir_pc),
    .o_misalign(misalign),
    .o_timeout(timeout)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // reset state
    pc_rst = 32'h0;
    i_rst = 1'b0;
    tick();
    settle();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_mis", 32'(misalign), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    i_rst = 1'b1;
    // START
    settle();
    chk("start_req", 32'(req), 32'd0);
    tick();
    // FETCH zero-wait
    ready = 1'b1;
    rdata = 32'h0050_0093;
    settle();
    chk("f0_req", 32'(req), 32'd1);
    chk("f0_addr", addr, 32'h0);
    chk("f0_en", 32'(en_pc), 32'd1);
    chk("f0_next", pc_next, 32'h4);
    tick();
    // ISSUE
    ready = 1'b0;
    settle();
    chk("i0_valid", 32'(valid), 32'd1);
    chk("i0_instr", instr, 32'h0050_0093);
    chk("i0_req", 32'(req), 32'd0);
    chk("i0_pc", pc, 32'h4);
    tick();
    // 3 wait states at address 4
    rdata = 32'h00A0_0113;
    for (int i = 0; i < 4; i++) begin
      ready = (i == 3);
      settle();
      chk("ws_req", 32'(req), 32'd1);
      chk("ws_addr", addr, 32'h4);
      chk("ws_en", 32'(en_pc), (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    ready = 1'b0;
    rdata = 32'h0;
    // stall held in ISSUE
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("st_instr", instr, 32'h00A0_0113);
      chk("st_valid", 32'(valid), 32'd1);
      chk("st_en", 32'(en_pc), 32'd0);
      tick();
    end
    // redirect in ISSUE while stalled
    redir = 1'b1;
    redir_pc = 32'h100;
    settle();
    chk("ri_en", 32'(en_pc), 32'd1);
    chk("ri_next", pc_next, 32'h100);
    tick();
    redir = 1'b0;
    stall = 1'b0;
    settle();
    chk("ri_valid", 32'(valid), 32'd0);
    chk("ri_req", 32'(req), 32'd1);
    chk("ri_addr", addr, 32'h100);
    chk("ri_to", 32'(timeout), 32'd0);
    // redirect 0x200 while waiting, then 0x300 in FLUSH
    redir = 1'b1;
    redir_pc = 32'h200;
    settle();
    chk("fl0_en", 32'(en_pc), 32'd0);
    tick();
    redir_pc = 32'h300;
    rdata = 32'hDEAD_BEEF;
    settle();
    chk("fl1_req", 32'(req), 32'd1);
    chk("fl1_addr", addr, 32'h100);
    chk("fl1_en", 32'(en_pc), 32'd0);
    tick();
    redir = 1'b0;
    settle();
    chk("fl2_addr", addr, 32'h100);
    chk("fl2_valid", 32'(valid), 32'd0);
    tick();
    ready = 1'b1;
    settle();
    chk("fl3_en", 32'(en_pc), 32'd1);
    chk("fl3_next", pc_next, 32'h300);
    tick();
    settle();
    chk("fl4_valid", 32'(valid), 32'd0);
    chk("fl4_addr", addr, 32'h300);
    // redirect to misaligned 0x102 with ready high
    redir = 1'b1;
    redir_pc = 32'h102;
    rdata = 32'h0000_0BAD;
    settle();
    chk("ma_en", 32'(en_pc), 32'd1);
    chk("ma_next", pc_next, 32'h100);
    tick();
    redir = 1'b0;
    rdata = 32'h0000_0013;
    settle();
    chk("ma_pulse", 32'(misalign), 32'd1);
    chk("ma_valid", 32'(valid), 32'd0);
    chk("ma_addr", addr, 32'h100);
    tick();
    ready = 1'b0;
    settle();
    chk("ma_clear", 32'(misalign), 32'd0);
    chk("ma_issue", 32'(valid), 32'd1);
    tick();
    // timeout: ready low for 6 cycles
    for (int k = 1; k <= 6; k++) begin
      settle();
      chk("to_wait", 32'(timeout), (k > 4) ? 32'd1 : 32'd0);
      tick();
    end
    ready = 1'b1;
    settle();
    chk("to_rdy", 32'(timeout), 32'd1);
    tick();
    ready = 1'b0;
    stall = 1'b1;
    settle();
    chk("to_hold", 32'(timeout), 32'd1);
    chk("to_valid", 32'(valid), 32'd1);
    // reset mid-operation, then PC wrap
    pc_rst = 32'hFFFF_FFFC;
    i_rst = 1'b0;
    settle();
    chk("mr_req", 32'(req), 32'd0);
    chk("mr_valid", 32'(valid), 32'd0);
    chk("mr_to", 32'(timeout), 32'd0);
    chk("mr_instr", instr, 32'h13);
    tick();
    i_rst = 1'b1;
    stall = 1'b0;
    ready = 1'b1;
    rdata = 32'h1234_5678;
    tick();
    settle();
    chk("wr_valid", 32'(valid), 32'd0);
    chk("wr_addr", addr, 32'hFFFF_FFFC);
    chk("wr_next", pc_next, 32'h0);
    chk("wr_en", 32'(en_pc), 32'd1);
    tick();
    ready = 1'b0;
    settle();
    chk("wr_instr", instr, 32'h1234_5678);
    chk("wr_pc", addr, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
